// File: rtl/hls_macc_result_sink.sv
// ---------------------------------------------------------------------------
// hls_macc_result_sink : packs hls_macc per-call outputs into records, FIFOs
// them onto a valid/ready stream, and accumulates ap_return.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hls_macc_result_sink #(
  parameter int DEPTH = 4,
  parameter int ACC_W = 48
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             macc_done,
  input  logic [31:0]      macc_return,
  input  logic [31:0]      out13,
  input  logic             out13_vld,
  input  logic [31:0]      out30,
  input  logic             out30_vld,
  input  logic [31:0]      out31,
  input  logic             out31_vld,
  output logic             start_ok,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [136:0]     m_data,
  output logic [ACC_W-1:0] acc,
  output logic [15:0]      drop_cnt,
  output logic             overflow,
  output logic             proto_err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]      s13_q, s13_d;
  logic [31:0]      s30_q, s30_d;
  logic             upd30_q, upd30_d;
  logic             pending_q, pending_d;
  logic [7:0]       seq_q, seq_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;
  logic             proto_err_q, proto_err_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [136:0]     mem_q [DEPTH];

  logic             pop;
  logic             push;
  logic             full;
  logic [136:0]     rec;

  always_comb begin
    full = (count_q == FULL_CNT);
    pop  = (count_q != '0) && m_ready;
    // A full FIFO still takes a record when the head leaves in the same cycle.
    push = macc_done && (!full || pop);
    rec  = {seq_q, upd30_q, (pending_q ? s13_q : 32'h0),
            (upd30_q ? s30_q : out30), out31, macc_return};

    s13_d       = s13_q;
    s30_d       = s30_q;
    upd30_d     = upd30_q;
    pending_d   = pending_q;
    seq_d       = seq_q;
    acc_d       = acc_q;
    drop_cnt_d  = drop_cnt_q;
    overflow_d  = overflow_q;
    proto_err_d = proto_err_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    if (macc_done) begin
      pending_d = 1'b0;
      upd30_d   = 1'b0;
      seq_d     = seq_q + 8'd1;
      if (!pending_q || !out31_vld) proto_err_d = 1'b1;
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        acc_d    = acc_q + ACC_W'($signed(macc_return));
      end else begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end

    // A back-to-back call start overrides the close for pending/s13.
    if (out13_vld) begin
      s13_d     = out13;
      pending_d = 1'b1;
      if (pending_q && !macc_done) proto_err_d = 1'b1;
    end

    if (out30_vld) begin
      s30_d   = out30;
      upd30_d = 1'b1;
    end

    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s13_q       <= '0;
      s30_q       <= '0;
      upd30_q     <= 1'b0;
      pending_q   <= 1'b0;
      seq_q       <= '0;
      acc_q       <= '0;
      drop_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      s13_q       <= s13_d;
      s30_q       <= s30_d;
      upd30_q     <= upd30_d;
      pending_q   <= pending_d;
      seq_q       <= seq_d;
      acc_q       <= acc_d;
      drop_cnt_q  <= drop_cnt_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Record storage needs no reset; m_data is masked while the FIFO is empty.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst && push) mem_q[wr_ptr_q] <= rec;
  end

  assign m_valid   = (count_q != '0);
  assign m_data    = m_valid ? mem_q[rd_ptr_q] : '0;
  assign start_ok  = !full && !pending_q;
  assign acc       = acc_q;
  assign drop_cnt  = drop_cnt_q;
  assign overflow  = overflow_q;
  assign proto_err = proto_err_q;

endmodule

`default_nettype wire

// File: tb/tb_hls_macc_result_sink.sv
// ---------------------------------------------------------------------------
// tb_hls_macc_result_sink : scoreboard bench for hls_macc_result_sink.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hls_macc_result_sink;

  logic         ap_clk = 1'b0;
  logic         ap_rst = 1'b1;
  logic         macc_done = 1'b0;
  logic [31:0]  macc_return = '0;
  logic [31:0]  out13 = '0;
  logic         out13_vld = 1'b0;
  logic [31:0]  out30 = '0;
  logic         out30_vld = 1'b0;
  logic [31:0]  out31 = '0;
  logic         out31_vld = 1'b0;
  logic         start_ok;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [136:0] m_data;
  logic [47:0]  acc;
  logic [15:0]  drop_cnt;
  logic         overflow;
  logic         proto_err;

  hls_macc_result_sink #(.DEPTH(4), .ACC_W(48)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .macc_done(macc_done),
    .macc_return(macc_return), .out13(out13), .out13_vld(out13_vld),
    .out30(out30), .out30_vld(out30_vld), .out31(out31), .out31_vld(out31_vld),
    .start_ok(start_ok), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .acc(acc), .drop_cnt(drop_cnt), .overflow(overflow), .proto_err(proto_err)
  );

  always #5 ap_clk = ~ap_clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [136:0] exp_q[$];
  logic [7:0]   seq_m = 8'd0;
  logic [47:0]  exp_acc = '0;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every popped record must match the oldest expectation.
  always @(negedge ap_clk) begin
    logic [136:0] e;
    if (!ap_rst && m_valid && m_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_record: got=%h expected=none", m_data);
      end else begin
        e = exp_q.pop_front();
        if (m_data !== e) begin
          n_fail++;
          $display("FAIL record: got=%h expected=%h", m_data, e);
        end
      end
    end
  end

  task automatic do_call(input logic [31:0] v13, input logic has30, input logic [31:0] v30,
                         input logic [31:0] live30, input logic [31:0] v31,
                         input logic [31:0] ret, input bit push_exp, input bit pop_at_close);
    out13     = v13;
    out13_vld = 1'b1;
    out30_vld = has30;
    out30     = has30 ? v30 : live30;
    tick();
    chk("start_ok_busy", 64'(start_ok), 64'd0);
    out13_vld   = 1'b0;
    out30_vld   = 1'b0;
    out30       = live30;
    macc_done   = 1'b1;
    macc_return = ret;
    out31       = v31;
    out31_vld   = 1'b1;
    if (pop_at_close) m_ready = 1'b1;
    if (push_exp) begin
      exp_q.push_back({seq_m, has30, v13, (has30 ? v30 : live30), v31, ret});
      exp_acc = exp_acc + {{16{ret[31]}}, ret};
    end
    seq_m = seq_m + 8'd1;
    tick();
    macc_done = 1'b0;
    out31_vld = 1'b0;
    if (pop_at_close) m_ready = 1'b0;
  endtask

  task automatic done_only(input logic [31:0] live30, input logic [31:0] v31, input logic [31:0] ret);
    out30       = live30;
    macc_done   = 1'b1;
    macc_return = ret;
    out31       = v31;
    out31_vld   = 1'b1;
    exp_q.push_back({seq_m, 1'b0, 32'h0, live30, v31, ret});
    exp_acc = exp_acc + {{16{ret[31]}}, ret};
    seq_m = seq_m + 8'd1;
    tick();
    macc_done = 1'b0;
    out31_vld = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_m_valid",   64'(m_valid),   64'd0);
    chk("rst_acc",       64'(acc),       64'd0);
    chk("rst_drop_cnt",  64'(drop_cnt),  64'd0);
    chk("rst_overflow",  64'(overflow),  64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    chk("rst_start_ok",  64'(start_ok),  64'd1);
    chk("rst_m_data",    64'(|m_data),   64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    ap_rst = 1'b0;
    chk_reset_state();

    // Single call, ret=-1, out30 passthrough
    m_ready = 1'b1;
    do_call(32'h10, 1'b0, 32'h0, 32'hAB, 32'h20, 32'hFFFF_FFFF, 1'b1, 1'b0);
    chk("m_valid_after_close", 64'(m_valid), 64'd1);
    chk("acc_single", 64'(acc), 64'hFFFF_FFFF_FFFF);
    chk("start_ok_idle", 64'(start_ok), 64'd1);

    // Staged out30 overrides the live value
    do_call(32'h1, 1'b1, 32'h55, 32'h99, 32'h2, 32'h5, 1'b1, 1'b0);
    chk("acc_upd30", 64'(acc), 64'h4);
    tick();

    // Back-pressure: four stored, fifth dropped
    m_ready = 1'b0;
    do_call(32'h21, 1'b0, 32'h0, 32'h31, 32'h41, 32'h1, 1'b1, 1'b0);
    do_call(32'h22, 1'b0, 32'h0, 32'h32, 32'h42, 32'h2, 1'b1, 1'b0);
    do_call(32'h23, 1'b0, 32'h0, 32'h33, 32'h43, 32'h3, 1'b1, 1'b0);
    do_call(32'h24, 1'b0, 32'h0, 32'h34, 32'h44, 32'h4, 1'b1, 1'b0);
    chk("start_ok_full", 64'(start_ok), 64'd0);
    do_call(32'h25, 1'b0, 32'h0, 32'h35, 32'h45, 32'h5, 1'b0, 1'b0);
    chk("drop_cnt_one", 64'(drop_cnt), 64'd1);
    chk("overflow_set", 64'(overflow), 64'd1);
    chk("acc_after_drop", 64'(acc), 64'd14);
    chk("m_valid_full", 64'(m_valid), 64'd1);

    // Full with simultaneous pop: accepted, stays full
    do_call(32'h26, 1'b0, 32'h0, 32'h36, 32'h46, 32'h7, 1'b1, 1'b1);
    chk("start_ok_still_full", 64'(start_ok), 64'd0);
    chk("drop_cnt_no_new_drop", 64'(drop_cnt), 64'd1);
    chk("acc_full_pop", 64'(acc), 64'd21);
    m_ready = 1'b1;
    repeat (6) tick();
    chk("drained_all", 64'(exp_q.size()), 64'd0);
    chk("m_valid_empty", 64'(m_valid), 64'd0);
    chk("proto_err_clean", 64'(proto_err), 64'd0);

    // Close without a call start
    done_only(32'h44, 32'h33, 32'h100);
    chk("proto_err_set", 64'(proto_err), 64'd1);
    chk("acc_proto", 64'(acc), 64'd277);
    do_call(32'h9, 1'b0, 32'h0, 32'h8, 32'h7, 32'h0, 1'b1, 1'b0);
    chk("proto_err_sticky", 64'(proto_err), 64'd1);

    // Run seq through 255 -> 0 -> 1
    for (int i = 0; i < 248; i++)
      do_call(32'(i), 1'b0, 32'h0, 32'(i + 1), 32'(i + 2), 32'h0, 1'b1, 1'b0);
    repeat (3) tick();
    chk("wrap_drained", 64'(exp_q.size()), 64'd0);
    chk("seq_model_wrapped", 64'(seq_m), 64'd2);
    chk("acc_after_wrap", 64'(acc), 64'd277);

    // Leave a record in the FIFO and a call open, then reset
    m_ready = 1'b0;
    do_call(32'h77, 1'b0, 32'h0, 32'h78, 32'h79, 32'h7A, 1'b0, 1'b0);
    out13     = 32'hDEAD;
    out13_vld = 1'b1;
    tick();
    ap_rst    = 1'b1;
    out13_vld = 1'b0;
    tick();
    ap_rst = 1'b0;
    chk_reset_state();
    seq_m   = 8'd0;
    exp_acc = '0;

    // Close after reset with nothing pending
    m_ready = 1'b1;
    done_only(32'h5, 32'h6, 32'h3);
    chk("proto_err_after_rst", 64'(proto_err), 64'd1);
    chk("acc_after_rst", 64'(acc), 64'd3);
    chk("acc_model", 64'(acc), 64'(exp_acc));
    repeat (3) tick();
    chk("final_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
